proj_out_drain: RTL and testbench
=================================

Name: proj_out_drain

Overview:
Consumer end of the projection unit's result interface.
- Captures one PE_NUM-wide set of Q/K/V accumulator results when the projection unit raises out_valid.
- Requantizes each result back to DW-bit signed.
- Drains the results one head per beat over a valid/ready stream toward the KV/attention buffers.
- Provides a ready indication back to the projection side.

Parameters:
- N, 32, vector length reduced by the projection unit.
- DW, 4, signed data width of the requantized outputs.
- PE_NUM, 12, number of heads/PEs per result set.
- ACC_W, 2*DW+$clog2(N), signed accumulator width of the inputs (13 at defaults).
- SHIFT, 3, requantization right shift; range 0..ACC_W-1.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- out_valid, in, 1, projection result valid (single-cycle pulse from the projection unit).
- out_q, in, [0:PE_NUM-1] x ACC_W signed, Q accumulators.
- out_k, in, [0:PE_NUM-1] x ACC_W signed, K accumulators.
- out_v, in, [0:PE_NUM-1] x ACC_W signed, V accumulators.
- drain_ready, out, 1, registered; high when a new result set can be captured.
- overrun, out, 1, one-cycle pulse when out_valid arrives while drain_ready=0.
- m_valid, out, 1, stream beat valid.
- m_ready, in, 1, downstream accept.
- m_head, out, $clog2(PE_NUM), head index of the current beat.
- m_q, out, DW signed, requantized Q of head m_head.
- m_k, out, DW signed, requantized K of head m_head.
- m_v, out, DW signed, requantized V of head m_head.
- m_last, out, 1, high on the beat with m_head=PE_NUM-1.

Behaviour:
Reset values (rst sampled high at a clock edge):
- state=IDLE, drain_ready=1, m_valid=0, m_head=0, m_last=0, overrun=0.
- Storage contents are don't-care; m_q/m_k/m_v are 0 while m_valid=0.

State machine:
- IDLE: out_valid && drain_ready at edge T → all 3*PE_NUM results requantized and stored; head counter=0; go to SEND.
  - drain_ready=0 from T+1.
  - m_valid=1, m_head=0 at T+1 (latency 1 cycle).
- SEND: m_valid=1.
  - m_valid && m_ready → head counter increments.
  - Handshake with m_last=1 → go to IDLE; m_valid=0 and drain_ready=1 on the next cycle.
  - m_ready low → m_head, m_q, m_k, m_v, m_last held stable; no beat skipped or duplicated.
- Throughput: one head per cycle when m_ready is held high; a full drain takes PE_NUM cycles.
- Back-to-back sets: a new capture is possible one cycle after the last handshake, so minimum set spacing is PE_NUM+1 cycles.

Overrun:
- out_valid while drain_ready=0, including the cycle of the last handshake → data ignored, overrun=1 for exactly one cycle, stored data and stream unaffected.

Requantization, per element, computed at capture:
- SHIFT>0: r = (x + 2^(SHIFT-1)) >>> SHIFT, using an arithmetic shift and ACC_W+1-bit intermediate (round half up).
- SHIFT=0: r = x.
- Saturate r to [-2^(DW-1), 2^(DW-1)-1], i.e. [-8, 7] at defaults.

Reset mid-drain: abandons the set immediately. Next cycle: m_valid=0, drain_ready=1, no residual beats.

Optional Feature:
SAT_CNT_EN
- Defined: adds output sat_count, 16 bits.
  - Increments by the number of elements saturated in each captured set (0..3*PE_NUM).
  - Sticks at 16'hFFFF; cleared by rst.
  - Overrun-dropped sets are not counted.
- Undefined: port and counter logic absent; behaviour otherwise identical.

Decomposition:
- Shared package proj_pkg:
  - acc_width function (2*DW+$clog2(N)).
  - drain state enum {IDLE, SEND}.
  - Saturation-bound constants derived from DW.
- Sub-module proj_requant: purely combinational; ACC_W in → DW out plus a sat flag; parameters ACC_W, DW, SHIFT. Instantiated 3*PE_NUM times in a generate loop.

Test Plan:
1. Defaults, m_ready=1; pulse out_valid with out_q[h]=8*min(h+1,7), out_k[h]=8*min(2(h+1),7), out_v[h]=8*min(3(h+1),7).
   - Beats h=0..11 on consecutive cycles starting 1 cycle after capture.
   - m_q: 1,2,3,4,5,6,7,7,7,7,7,7.
   - m_k: 2,4,6,7,7,...
   - m_v: 3,6,7,7,...
   - m_last only on h=11; drain_ready high again the cycle after.
2. Rounding/saturation on head 0: x = 11,12,-12,-13,100,-100 → 1,2,-1,-2,7,-8.
3. Backpressure: m_ready toggles 1,0,0,1,... → every head appears exactly once, in order; m_* stable during stalls; total beats = 12.
4. out_valid reasserted at beat 5 and again in the cycle of the last handshake → overrun pulses once each, stream of the first set unchanged, state IDLE after drain.
5. rst asserted during beat 6 with m_ready=1 → next cycle m_valid=0, drain_ready=1. A new set captured afterwards drains from head 0.
6. With SAT_CNT_EN, scenario 1 → sat_count = 0. Then a set with all inputs 100 → sat_count = 36; it holds at 16'hFFFF once that value is reached.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared types and helpers for the projection result path: accumulator width,
// drain FSM states and signed saturation bounds.
package proj_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Saturation bounds of a dw-bit two's-complement value.
  function automatic int sat_hi(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/proj_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift of a signed
// accumulator, then saturation to DW bits with a flag when clipping occurs.
module proj_requant
  import proj_pkg::*;
#(
  parameter int ACC_W = 13,
  parameter int DW    = 4,
  parameter int SHIFT = 3
) (
  input  logic signed [ACC_W-1:0] x,
  output logic signed [DW-1:0]    r,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] HI  = (ACC_W+1)'(sat_hi(DW));
  localparam logic signed [ACC_W:0] LO  = (ACC_W+1)'(sat_lo(DW));
  // Half-LSB rounding constant; evaluates to zero when SHIFT is zero.
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((2 ** SHIFT) / 2);

  logic signed [ACC_W:0] wide;

  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] e;
    e = {a[ACC_W-1], a};
    return (e + RND) >>> SHIFT;
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > HI) begin
      return HI[DW-1:0];
    end else if (v < LO) begin
      return LO[DW-1:0];
    end
    return v[DW-1:0];
  endfunction

  always_comb begin
    wide = round_shift(x);
    r    = saturate(wide);
    sat  = (wide > HI) || (wide < LO);
  end

endmodule

// File: rtl/proj_out_drain.sv
// Captures one set of Q/K/V accumulators, requantizes them and drains one head
// per beat over a valid/ready stream. Optional SAT_CNT_EN adds a saturation counter.
module proj_out_drain
  import proj_pkg::*;
#(
  parameter int N      = 32,
  parameter int DW     = 4,
  parameter int PE_NUM = 12,
  parameter int ACC_W  = acc_width(DW, N),
  parameter int SHIFT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        out_valid,
  input  logic signed [ACC_W-1:0]     out_q [0:PE_NUM-1],
  input  logic signed [ACC_W-1:0]     out_k [0:PE_NUM-1],
  input  logic signed [ACC_W-1:0]     out_v [0:PE_NUM-1],
  output logic                        drain_ready,
  output logic                        overrun,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(PE_NUM)-1:0]   m_head,
  output logic signed [DW-1:0]        m_q,
  output logic signed [DW-1:0]        m_k,
  output logic signed [DW-1:0]        m_v,
  output logic                        m_last
`ifdef SAT_CNT_EN
  ,
  output logic [15:0]                 sat_count
`endif
);

  localparam int HW   = $clog2(PE_NUM);
  localparam int NSAT = 3 * PE_NUM;
  localparam logic [HW-1:0] LAST_HEAD = HW'(PE_NUM - 1);

  drain_state_e state_q, state_d;
  logic [HW-1:0] head_q, head_d;
  logic drain_ready_q, drain_ready_d;
  logic overrun_q, overrun_d;
  logic capture;

  logic signed [DW-1:0] q_rq [PE_NUM];
  logic signed [DW-1:0] k_rq [PE_NUM];
  logic signed [DW-1:0] v_rq [PE_NUM];
  logic [NSAT-1:0] sat_flag;

  logic signed [DW-1:0] q_buf_q [PE_NUM];
  logic signed [DW-1:0] k_buf_q [PE_NUM];
  logic signed [DW-1:0] v_buf_q [PE_NUM];
  logic signed [DW-1:0] q_buf_d [PE_NUM];
  logic signed [DW-1:0] k_buf_d [PE_NUM];
  logic signed [DW-1:0] v_buf_d [PE_NUM];

  for (genvar h = 0; h < PE_NUM; h++) begin : g_pe
    proj_requant #(.ACC_W(ACC_W), .DW(DW), .SHIFT(SHIFT)) u_rq_q (
      .x(out_q[h]), .r(q_rq[h]), .sat(sat_flag[h])
    );
    proj_requant #(.ACC_W(ACC_W), .DW(DW), .SHIFT(SHIFT)) u_rq_k (
      .x(out_k[h]), .r(k_rq[h]), .sat(sat_flag[PE_NUM + h])
    );
    proj_requant #(.ACC_W(ACC_W), .DW(DW), .SHIFT(SHIFT)) u_rq_v (
      .x(out_v[h]), .r(v_rq[h]), .sat(sat_flag[2*PE_NUM + h])
    );
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_valid && drain_ready_q) begin
          capture = 1'b1;
          head_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (head_q == LAST_HEAD) begin
            state_d = IDLE;
            head_d  = '0;
          end else begin
            head_d = head_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    drain_ready_d = (state_d == IDLE);
    // A pulse during the final handshake still counts as an overrun.
    overrun_d     = out_valid && !drain_ready_q;
  end

  always_comb begin
    q_buf_d = q_buf_q;
    k_buf_d = k_buf_q;
    v_buf_d = v_buf_q;
    if (capture) begin
      q_buf_d = q_rq;
      k_buf_d = k_rq;
      v_buf_d = v_rq;
    end
  end

  // Capture stage boundary: control flops reset, result storage does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_q        <= '0;
      drain_ready_q <= 1'b1;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      drain_ready_q <= drain_ready_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    q_buf_q <= q_buf_d;
    k_buf_q <= k_buf_d;
    v_buf_q <= v_buf_d;
  end

  assign drain_ready = drain_ready_q;
  assign overrun     = overrun_q;
  assign m_valid     = (state_q == SEND);
  assign m_head      = head_q;
  assign m_last      = m_valid && (head_q == LAST_HEAD);
  assign m_q         = m_valid ? q_buf_q[head_q] : '0;
  assign m_k         = m_valid ? k_buf_q[head_q] : '0;
  assign m_v         = m_valid ? v_buf_q[head_q] : '0;

`ifdef SAT_CNT_EN
  localparam int CW = $clog2(NSAT + 1);

  logic [CW-1:0] n_sat;
  logic [16:0]   sat_sum;
  logic [15:0]   sat_cnt_q, sat_cnt_d;

  always_comb begin
    n_sat = '0;
    for (int i = 0; i < NSAT; i++) begin
      n_sat = n_sat + CW'(sat_flag[i]);
    end
    sat_sum   = {1'b0, sat_cnt_q} + 17'(n_sat);
    sat_cnt_d = sat_cnt_q;
    if (capture) begin
      sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  logic sat_unused;
  assign sat_unused = ^sat_flag;
`endif

endmodule

// File: tb/tb_proj_out_drain.sv
// Directed self-checking bench for proj_out_drain at default parameters.
module tb_proj_out_drain;

  localparam int PE    = 12;
  localparam int ACC_W = 13;
  localparam int DW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, out_valid, m_ready;
  logic signed [ACC_W-1:0] out_q [0:PE-1];
  logic signed [ACC_W-1:0] out_k [0:PE-1];
  logic signed [ACC_W-1:0] out_v [0:PE-1];
  logic drain_ready, overrun, m_valid, m_last;
  logic [3:0] m_head;
  logic signed [DW-1:0] m_q, m_k, m_v;
`ifdef SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  proj_out_drain dut (
    .clk(clk), .rst(rst), .out_valid(out_valid),
    .out_q(out_q), .out_k(out_k), .out_v(out_v),
    .drain_ready(drain_ready), .overrun(overrun),
    .m_valid(m_valid), .m_ready(m_ready), .m_head(m_head),
    .m_q(m_q), .m_k(m_k), .m_v(m_v), .m_last(m_last)
`ifdef SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  typedef struct {
    int x;
    int r;
  } rq_vec_t;

  int total = 0;
  int bad   = 0;
  int eq [PE];
  int ek [PE];
  int ev [PE];
  rq_vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int min7(input int a);
    return (a < 7) ? a : 7;
  endfunction

  task automatic load_pattern1();
    for (int h = 0; h < PE; h++) begin
      out_q[h] = ACC_W'(8 * min7(h + 1));
      out_k[h] = ACC_W'(8 * min7(2 * (h + 1)));
      out_v[h] = ACC_W'(8 * min7(3 * (h + 1)));
    end
  endtask

  task automatic set_all(input int val);
    for (int h = 0; h < PE; h++) begin
      out_q[h] = ACC_W'(val);
      out_k[h] = ACC_W'(val);
      out_v[h] = ACC_W'(val);
    end
  endtask

  task automatic pulse();
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(drain_ready === 1'b1 && m_valid === 1'b0) && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL %s: drain did not finish within %0d cycles", nm, n);
    end
  endtask

  initial begin
    eq = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7, 7};
    ek = '{2, 4, 6, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    ev = '{3, 6, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    vecs = '{'{11, 1}, '{12, 2}, '{-12, -1}, '{-13, -2}, '{100, 7}, '{-100, -8}};

    rst = 1'b1;
    out_valid = 1'b0;
    m_ready = 1'b1;
    set_all(0);
    tick();
    tick();
    chk("rst_drain_ready", drain_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_head", m_head, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_m_q", m_q, 0);
    rst = 1'b0;
    tick();

    // Full drain at one head per cycle.
    load_pattern1();
    pulse();
    chk("t1_drain_ready_low", drain_ready, 0);
    for (int h = 0; h < PE; h++) begin
      chk("t1_m_valid", m_valid, 1);
      chk("t1_m_head", m_head, h);
      chk("t1_m_q", m_q, eq[h]);
      chk("t1_m_k", m_k, ek[h]);
      chk("t1_m_v", m_v, ev[h]);
      chk("t1_m_last", m_last, (h == PE - 1) ? 1 : 0);
      tick();
    end
    chk("t1_end_m_valid", m_valid, 0);
    chk("t1_end_drain_ready", drain_ready, 1);
    chk("t1_end_m_q", m_q, 0);
`ifdef SAT_CNT_EN
    chk("t6_sat_count_zero", sat_count, 0);
`endif

    // Rounding and saturation table on head 0.
    for (int i = 0; i < 6; i++) begin
      load_pattern1();
      out_q[0] = ACC_W'(vecs[i].x);
      out_k[0] = ACC_W'(vecs[i].x);
      out_v[0] = ACC_W'(vecs[i].x);
      pulse();
      chk("t2_m_head", m_head, 0);
      chk("t2_m_q", m_q, vecs[i].r);
      chk("t2_m_k", m_k, vecs[i].r);
      chk("t2_m_v", m_v, vecs[i].r);
      wait_idle("t2_drain");
    end

    // Backpressure: m_ready pattern 1,0,0 repeating.
    begin
      int exp_head, beats, c;
      logic hs;
      load_pattern1();
      pulse();
      exp_head = 0;
      beats = 0;
      c = 0;
      while (beats < PE && c < 100) begin
        m_ready = (c % 3 == 0);
        chk("t3_m_valid", m_valid, 1);
        chk("t3_m_head", m_head, exp_head);
        chk("t3_m_q", m_q, eq[exp_head]);
        chk("t3_m_v", m_v, ev[exp_head]);
        hs = m_valid && m_ready;
        tick();
        if (hs) begin
          beats++;
          exp_head++;
        end
        c++;
      end
      m_ready = 1'b1;
      chk("t3_beats", beats, PE);
      chk("t3_end_m_valid", m_valid, 0);
      chk("t3_end_drain_ready", drain_ready, 1);
    end

    // Overrun mid-drain and on the final handshake.
    load_pattern1();
    pulse();
    set_all(100);
    for (int h = 0; h < PE; h++) begin
      chk("t4_m_head", m_head, h);
      chk("t4_m_q", m_q, eq[h]);
      chk("t4_m_k", m_k, ek[h]);
      out_valid = (h == 5 || h == PE - 1);
      tick();
      out_valid = 1'b0;
      chk("t4_overrun", overrun, (h == 5 || h == PE - 1) ? 1 : 0);
    end
    chk("t4_end_m_valid", m_valid, 0);
    chk("t4_end_drain_ready", drain_ready, 1);
    tick();
    chk("t4_idle_m_valid", m_valid, 0);
    chk("t4_idle_overrun", overrun, 0);

    // Reset in the middle of a drain.
    load_pattern1();
    pulse();
    for (int h = 0; h < 6; h++) tick();
    chk("t5_head_before_rst", m_head, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_drain_ready", drain_ready, 1);
    chk("t5_m_head", m_head, 0);
    tick();
    chk("t5_no_residual", m_valid, 0);
    pulse();
    chk("t5_new_head", m_head, 0);
    chk("t5_new_m_q", m_q, 1);
    chk("t5_new_m_v", m_v, 3);
    wait_idle("t5_drain");

`ifdef SAT_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_sat_count_rst", sat_count, 0);
    set_all(100);
    pulse();
    wait_idle("t6_drain");
    chk("t6_sat_count_36", sat_count, 36);
    for (int s = 1; s < 1820; s++) begin
      pulse();
      for (int h = 0; h < PE; h++) tick();
    end
    chk("t6_sat_count_65520", sat_count, 65520);
    pulse();
    wait_idle("t6_drain_sat");
    chk("t6_sat_count_sticky", sat_count, 32'hFFFF);
    pulse();
    wait_idle("t6_drain_sat2");
    chk("t6_sat_count_hold", sat_count, 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
